// File: rtl/round_timer.sv
// rtl/round_timer.sv - round countdown timer fed by divided clocks; optional blinking warn under WARN_BLINK_EN
module round_timer #(
  parameter int SYNC_STAGES = 2,
  parameter int SECS_W      = 6,
  parameter int WARN_SECS   = 3
) (
  input  logic              masterclk,
  input  logic              rst,
  input  logic              onehzclk,
  input  logic              fastclk,
  input  logic              start,
  input  logic [SECS_W-1:0] load_secs,
  input  logic              pause,
  input  logic              ack,
  output logic              sec_tick,
  output logic              fast_tick,
  output logic              busy,
  output logic              expired,
  output logic [SECS_W-1:0] secs_left,
  output logic              warn
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  localparam int WARM_W = $clog2(SYNC_STAGES + 2);

  logic [SYNC_STAGES-1:0] sec_sync_q;
  logic [SYNC_STAGES-1:0] fast_sync_q;
  logic                   sec_prev_q;
  logic                   fast_prev_q;
  logic                   sec_tick_q;
  logic                   fast_tick_q;
  logic [WARM_W-1:0]      warm_q;
  logic                   warm_done;

  state_t                 state_q;
  logic [SECS_W-1:0]      secs_left_q;
  logic                   busy_q;
  logic                   expired_q;
  logic                   in_window;

  // Ticks stay gated until the synchroniser and edge flops hold real samples,
  // so a divider output already high at reset release is not seen as an edge.
  assign warm_done = (warm_q == WARM_W'(SYNC_STAGES + 1));

  // Synchronise both divided clocks and turn their rising edges into 1-cycle ticks
  always_ff @(posedge masterclk or posedge rst) begin
    if (rst) begin
      sec_sync_q  <= '0;
      fast_sync_q <= '0;
      sec_prev_q  <= 1'b0;
      fast_prev_q <= 1'b0;
      sec_tick_q  <= 1'b0;
      fast_tick_q <= 1'b0;
      warm_q      <= '0;
    end else begin
      sec_sync_q  <= {sec_sync_q[SYNC_STAGES-2:0], onehzclk};
      fast_sync_q <= {fast_sync_q[SYNC_STAGES-2:0], fastclk};
      sec_prev_q  <= sec_sync_q[SYNC_STAGES-1];
      fast_prev_q <= fast_sync_q[SYNC_STAGES-1];
      sec_tick_q  <= warm_done & sec_sync_q[SYNC_STAGES-1] & ~sec_prev_q;
      fast_tick_q <= warm_done & fast_sync_q[SYNC_STAGES-1] & ~fast_prev_q;
      if (!warm_done) begin
        warm_q <= warm_q + 1'b1;
      end
    end
  end

  // Round FSM: start has priority over pause and tick; EXPIRED waits only for ack
  always_ff @(posedge masterclk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      secs_left_q <= '0;
      busy_q      <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, RUN, PAUSED: begin
          if (start) begin
            secs_left_q <= load_secs;
            if (load_secs == '0) begin
              state_q   <= EXPIRED;
              busy_q    <= 1'b0;
              expired_q <= 1'b1;
            end else begin
              state_q   <= RUN;
              busy_q    <= 1'b1;
              expired_q <= 1'b0;
            end
          end else if (state_q == RUN) begin
            if (pause) begin
              state_q <= PAUSED;
            end else if (sec_tick_q) begin
              if (secs_left_q <= SECS_W'(1)) begin
                secs_left_q <= '0;
                state_q     <= EXPIRED;
                busy_q      <= 1'b0;
                expired_q   <= 1'b1;
              end else begin
                secs_left_q <= secs_left_q - 1'b1;
              end
            end
          end else if (state_q == PAUSED) begin
            if (!pause) begin
              state_q <= RUN;
            end
          end
        end
        EXPIRED: begin
          if (ack) begin
            state_q   <= IDLE;
            expired_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          secs_left_q <= '0;
          busy_q      <= 1'b0;
          expired_q   <= 1'b0;
        end
      endcase
    end
  end

  assign in_window = (state_q == RUN) && (secs_left_q != '0) &&
                     (secs_left_q <= SECS_W'(WARN_SECS));

`ifdef WARN_BLINK_EN
  logic [7:0] blink_cnt_q;
  logic       blink_q;

  // Toggle the warn phase every 250 fast ticks while inside the warning window
  always_ff @(posedge masterclk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (!in_window) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (fast_tick_q) begin
      if (blink_cnt_q == 8'd249) begin
        blink_cnt_q <= '0;
        blink_q     <= ~blink_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign warn = in_window & blink_q;
`else
  assign warn = in_window;
`endif

  assign sec_tick  = sec_tick_q;
  assign fast_tick = fast_tick_q;
  assign busy      = busy_q;
  assign expired   = expired_q;
  assign secs_left = secs_left_q;

endmodule

// File: tb/tb_round_timer.sv
// tb/tb_round_timer.sv - directed and randomized checks of round_timer against a cycle reference model
module tb_round_timer;

  localparam int SS = 2;
  localparam int SW = 6;
  localparam int WS = 3;
  localparam int HD = SS + 2;

  logic          masterclk = 1'b0;
  logic          rst       = 1'b1;
  logic          onehzclk  = 1'b0;
  logic          fastclk   = 1'b0;
  logic          start     = 1'b0;
  logic [SW-1:0] load_secs = '0;
  logic          pause     = 1'b0;
  logic          ack       = 1'b0;
  logic          sec_tick;
  logic          fast_tick;
  logic          busy;
  logic          expired;
  logic [SW-1:0] secs_left;
  logic          warn;

  round_timer #(.SYNC_STAGES(SS), .SECS_W(SW), .WARN_SECS(WS)) dut (
    .masterclk (masterclk),
    .rst       (rst),
    .onehzclk  (onehzclk),
    .fastclk   (fastclk),
    .start     (start),
    .load_secs (load_secs),
    .pause     (pause),
    .ack       (ack),
    .sec_tick  (sec_tick),
    .fast_tick (fast_tick),
    .busy      (busy),
    .expired   (expired),
    .secs_left (secs_left),
    .warn      (warn)
  );

  always #5 masterclk = ~masterclk;

  int tests = 0;
  int fails = 0;

  // Reference model: round status flags, seconds count, input sample histories
  bit m_run, m_paused, m_expired;
  int m_secs;
  bit h_sec[HD];
  bit h_fast[HD];
  int edges;
  bit exp_sec, exp_fast;
  int m_bcnt;
  bit m_btog;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_paused = 0; m_expired = 0; m_secs = 0;
    for (int i = 0; i < HD; i++) begin
      h_sec[i] = 0;
      h_fast[i] = 0;
    end
    edges = 0; exp_sec = 0; exp_fast = 0; m_bcnt = 0; m_btog = 0;
  endtask

  // Advance the model by one clock using the present inputs, clock the DUT, compare
  task automatic cycle();
    bit t, ft, win, exp_warn;
    t   = exp_sec;
    ft  = exp_fast;
    win = m_run && m_secs >= 1 && m_secs <= WS;
    if (!win) begin
      m_bcnt = 0; m_btog = 0;
    end else if (ft) begin
      m_bcnt++;
      if (m_bcnt == 250) begin
        m_bcnt = 0; m_btog = !m_btog;
      end
    end
    if (m_expired) begin
      if (ack) m_expired = 0;
    end else if (start) begin
      m_secs    = int'(load_secs);
      m_expired = (load_secs == 0);
      m_run     = !m_expired;
      m_paused  = 0;
    end else if (m_run) begin
      if (pause) begin
        m_run = 0; m_paused = 1;
      end else if (t) begin
        m_secs = m_secs - 1;
        if (m_secs == 0) begin
          m_run = 0; m_expired = 1;
        end
      end
    end else if (m_paused) begin
      if (!pause) begin
        m_paused = 0; m_run = 1;
      end
    end
    for (int i = HD - 1; i > 0; i--) begin
      h_sec[i]  = h_sec[i-1];
      h_fast[i] = h_fast[i-1];
    end
    h_sec[0]  = onehzclk;
    h_fast[0] = fastclk;
    edges++;
    exp_sec  = (edges >= SS + 2) && h_sec[SS] && !h_sec[SS+1];
    exp_fast = (edges >= SS + 2) && h_fast[SS] && !h_fast[SS+1];
`ifdef WARN_BLINK_EN
    exp_warn = m_run && m_secs >= 1 && m_secs <= WS && m_btog;
`else
    exp_warn = m_run && m_secs >= 1 && m_secs <= WS;
`endif
    @(posedge masterclk);
    #1;
    chk("sec_tick", sec_tick, exp_sec);
    chk("fast_tick", fast_tick, exp_fast);
    chk("busy", busy, m_run || m_paused);
    chk("expired", expired, m_expired);
    chk("secs_left", secs_left, m_secs);
    chk("warn", warn, exp_warn);
  endtask

  // Raise onehzclk and run until its tick is the visible one for the next edge
  task automatic sec_to_visible();
    onehzclk = 1'b1;
    repeat (SS + 1) cycle();
  endtask

  task automatic sec_pulse();
    sec_to_visible();
    cycle();
    onehzclk = 1'b0;
    repeat (SS + 1) cycle();
  endtask

  initial begin
    int oc, fc;
    model_reset();

    // Reset with the 1 Hz divider output already high
    onehzclk = 1'b1;
    repeat (2) @(posedge masterclk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_expired", expired, 0);
    chk("rst_secs", secs_left, 0);
    chk("rst_sec_tick", sec_tick, 0);
    rst = 1'b0;
    repeat (8) cycle();
    chk("warm_no_tick", sec_tick, 0);

    // Tick latency on both inputs, and no tick on falling edges
    onehzclk = 1'b0;
    repeat (4) cycle();
    onehzclk = 1'b1;
    repeat (2) cycle();
    chk("lat_sec_early", sec_tick, 0);
    cycle();
    chk("lat_sec_n3", sec_tick, 1);
    cycle();
    chk("lat_sec_once", sec_tick, 0);
    onehzclk = 1'b0;
    repeat (4) cycle();
    fastclk = 1'b1;
    repeat (3) cycle();
    chk("lat_fast_n3", fast_tick, 1);
    fastclk = 1'b0;
    repeat (4) cycle();

    // Normal round of 3 seconds
    start = 1'b1; load_secs = 6'd3;
    cycle();
    start = 1'b0;
    chk("round_load", secs_left, 3);
    chk("round_busy", busy, 1);
    repeat (3) sec_pulse();
    chk("round_expired", expired, 1);
    chk("round_idle_busy", busy, 0);
    chk("round_zero", secs_left, 0);
    ack = 1'b1; start = 1'b1; load_secs = 6'd7;
    cycle();
    ack = 1'b0; start = 1'b0;
    chk("ack_clears", expired, 0);
    chk("ack_ignores_start", busy, 0);

    // Zero-length round
    start = 1'b1; load_secs = 6'd0;
    cycle();
    start = 1'b0;
    chk("load0_expired", expired, 1);
    ack = 1'b1;
    cycle();
    ack = 1'b0;

    // start coinciding with a tick while running
    start = 1'b1; load_secs = 6'd4;
    cycle();
    start = 1'b0;
    sec_to_visible();
    start = 1'b1; load_secs = 6'd5;
    cycle();
    start = 1'b0;
    onehzclk = 1'b0;
    chk("start_beats_tick", secs_left, 5);
    repeat (3) cycle();

    // Pause holds the count, no tick is owed afterwards
    sec_pulse();
    pause = 1'b1;
    cycle();
    repeat (4) sec_pulse();
    chk("pause_hold", secs_left, 4);
    chk("pause_busy", busy, 1);
    pause = 1'b0;
    cycle();
    sec_pulse();
    chk("resume_dec", secs_left, 3);
    chk("warn_window", warn, 0 `ifndef WARN_BLINK_EN | 1 `endif);
    sec_to_visible();
    pause = 1'b1;
    cycle();
    onehzclk = 1'b0;
    chk("pause_tick_drop", secs_left, 3);
    pause = 1'b0;
    repeat (3) cycle();

`ifdef WARN_BLINK_EN
    // 250 fast ticks inside the window flip the blink phase
    for (int i = 0; i < 250; i++) begin
      fastclk = 1'b1;
      repeat (2) cycle();
      fastclk = 1'b0;
      repeat (2) cycle();
    end
    chk("blink_on", warn, 1);
`endif

    // Asynchronous reset mid-round
    sec_pulse();
    chk("pre_rst_secs", secs_left, 2);
    rst = 1'b1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_secs", secs_left, 0);
    chk("async_warn", warn, 0);
    chk("async_expired", expired, 0);
    @(posedge masterclk);
    #1;
    rst = 1'b0;
    model_reset();

    // Randomized traffic against the model
    oc = 0; fc = 0;
    for (int i = 0; i < 4000; i++) begin
      if (oc == 0) begin
        onehzclk = ~onehzclk; oc = $urandom_range(3, 12);
      end else begin
        oc--;
      end
      if (fc == 0) begin
        fastclk = ~fastclk; fc = $urandom_range(1, 4);
      end else begin
        fc--;
      end
      start = ($urandom_range(0, 39) == 0);
      if (start) load_secs = SW'($urandom_range(0, 7));
      if ($urandom_range(0, 24) == 0) pause = ~pause;
      ack = ($urandom_range(0, 7) == 0);
      cycle();
    end
    start = 1'b0; ack = 1'b0; pause = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
